// File: rtl/gol_pkg.sv
// Shared constants and helpers for the Game of Life engine.
package gol_pkg;

  localparam int GOL_N     = 16;
  localparam int GOL_CNT_W = 32;

  // Flat board index of cell (r,c); row-major, row 0 in the low bits.
  function automatic int cell_idx(input int r, input int c);
    return r * GOL_N + c;
  endfunction

endpackage

// File: rtl/gol_cell_next.sv
// Single-cell B3/S23 next-state evaluator. Neighbour bits outside the board
// are expected to arrive already tied to 0 by the caller.
module gol_cell_next (
  input  logic       self_i,
  input  logic [7:0] nbr_i,
  output logic       next_o,
  output logic       born_o,
  output logic       died_o
);

  logic [3:0] count;

  // Count live neighbours and apply survive-on-2/3, birth-on-3.
  always_comb begin
    count = '0;
    for (int k = 0; k < 8; k++) begin
      count = count + 4'(nbr_i[k]);
    end
    next_o = (count == 4'd3) | (self_i & (count == 4'd2));
    born_o = ~self_i & next_o;
    died_o = self_i & ~next_o;
  end

endmodule

// File: rtl/gol_algorithm_machine.sv
// Game of Life next-generation engine: holds the board, steps it one
// generation per enabled clock and keeps cumulative birth/death/generation
// counters. Every cell is computed from the old board only.
module gol_algorithm_machine
  import gol_pkg::*;
#(
  parameter int N     = GOL_N,
  parameter int CNT_W = GOL_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               load,
  input  logic [N*N-1:0]     load_board,
  output logic [N*N-1:0]     board,
  output logic [CNT_W-1:0]   birth_cnt,
  output logic [CNT_W-1:0]   death_cnt,
  output logic [CNT_W-1:0]   gen_cnt
);

  localparam int CELLS  = N * N;
  localparam int CW     = $clog2(CELLS + 1);
  localparam int LEAVES = 1 << $clog2(CELLS);

  logic [CELLS-1:0] board_q, board_d;
  logic [CNT_W-1:0] birth_cnt_q, birth_cnt_d;
  logic [CNT_W-1:0] death_cnt_q, death_cnt_d;
  logic [CNT_W-1:0] gen_cnt_q, gen_cnt_d;

  logic [CELLS-1:0] nextBoard;
  logic [CELLS-1:0] bornVec;
  logic [CELLS-1:0] diedVec;

  // Board surrounded by a ring of permanently dead cells so that edge and
  // corner cells see zeros instead of wrapping around.
  logic [N+1:0][N+1:0] pad;

  logic [CW-1:0] birthNode [1:2*LEAVES-1];
  logic [CW-1:0] deathNode [1:2*LEAVES-1];
  logic [CW-1:0] births;
  logic [CW-1:0] deaths;

  // Embed the current board in the zero-padded frame.
  always_comb begin
    pad = '0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        pad[r+1][c+1] = board_q[r*N+c];
      end
    end
  end

  // One evaluator per cell; pad[gr+1][gc+1] is the cell itself.
  for (genvar gr = 0; gr < N; gr++) begin : g_row
    for (genvar gc = 0; gc < N; gc++) begin : g_col
      gol_cell_next u_cell (
        .self_i (board_q[gr*N+gc]),
        .nbr_i  ({pad[gr][gc],   pad[gr][gc+1],   pad[gr][gc+2],
                  pad[gr+1][gc],                  pad[gr+1][gc+2],
                  pad[gr+2][gc], pad[gr+2][gc+1], pad[gr+2][gc+2]}),
        .next_o (nextBoard[gr*N+gc]),
        .born_o (bornVec[gr*N+gc]),
        .died_o (diedVec[gr*N+gc])
      );
    end
  end

  // Balanced binary adder trees counting births and deaths; leaves sit at
  // LEAVES..2*LEAVES-1 and node i sums children 2i and 2i+1.
  always_comb begin
    for (int i = 0; i < LEAVES; i++) begin
      if (i < CELLS) begin
        birthNode[LEAVES+i] = CW'(bornVec[i]);
        deathNode[LEAVES+i] = CW'(diedVec[i]);
      end else begin
        birthNode[LEAVES+i] = '0;
        deathNode[LEAVES+i] = '0;
      end
    end
    for (int i = LEAVES - 1; i >= 1; i--) begin
      birthNode[i] = birthNode[2*i] + birthNode[2*i+1];
      deathNode[i] = deathNode[2*i] + deathNode[2*i+1];
    end
    births = birthNode[1];
    deaths = deathNode[1];
  end

  // Next-state selection: load beats enable, otherwise hold.
  always_comb begin
    board_d     = board_q;
    birth_cnt_d = birth_cnt_q;
    death_cnt_d = death_cnt_q;
    gen_cnt_d   = gen_cnt_q;
    if (load) begin
      board_d     = load_board;
      birth_cnt_d = '0;
      death_cnt_d = '0;
      gen_cnt_d   = '0;
    end else if (enable) begin
      board_d     = nextBoard;
      birth_cnt_d = birth_cnt_q + CNT_W'(births);
      death_cnt_d = death_cnt_q + CNT_W'(deaths);
      gen_cnt_d   = gen_cnt_q + CNT_W'(1);
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      board_q     <= '0;
      birth_cnt_q <= '0;
      death_cnt_q <= '0;
      gen_cnt_q   <= '0;
    end else begin
      board_q     <= board_d;
      birth_cnt_q <= birth_cnt_d;
      death_cnt_q <= death_cnt_d;
      gen_cnt_q   <= gen_cnt_d;
    end
  end

  assign board     = board_q;
  assign birth_cnt = birth_cnt_q;
  assign death_cnt = death_cnt_q;
  assign gen_cnt   = gen_cnt_q;

endmodule

// File: tb/tb_gol_algorithm_machine.sv
// Directed bench for the Game of Life engine using hand-derived patterns.
module tb_gol_algorithm_machine;
  import gol_pkg::*;

  localparam int CELLS = GOL_N * GOL_N;

  logic             clk;
  logic             reset;
  logic             enable;
  logic             load;
  logic [CELLS-1:0] load_board;
  logic [CELLS-1:0] board;
  logic [31:0]      birth_cnt;
  logic [31:0]      death_cnt;
  logic [31:0]      gen_cnt;

  int tests;
  int failures;

  gol_algorithm_machine dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .load       (load),
    .load_board (load_board),
    .board      (board),
    .birth_cnt  (birth_cnt),
    .death_cnt  (death_cnt),
    .gen_cnt    (gen_cnt)
  );

  // 100 MHz free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [CELLS-1:0] setCell(input logic [CELLS-1:0] b,
                                               input int r, input int c);
    logic [CELLS-1:0] t;
    t = b;
    t[cell_idx(r, c)] = 1'b1;
    return t;
  endfunction

  // Drive one cycle of inputs at the falling edge, then settle 1ns past the
  // following rising edge for sampling.
  task automatic applyStimulus(input logic ld, input logic en,
                               input logic [CELLS-1:0] lb);
    @(negedge clk);
    load       = ld;
    enable     = en;
    load_board = lb;
    @(posedge clk);
    #1;
    load   = 1'b0;
    enable = 1'b0;
  endtask

  task automatic test_reset();
    logic [CELLS-1:0] b;
    b = '1;
    reset = 1'b1;
    @(negedge clk);
    load = 1'b1;
    enable = 1'b1;
    load_board = b;
    @(posedge clk);
    #1;
    tests++;
    if (board !== '0) begin
      failures++;
      $display("[TB] FAIL reset_board got=%h exp=0", board);
    end
    tests++;
    if ({birth_cnt, death_cnt, gen_cnt} !== 96'd0) begin
      failures++;
      $display("[TB] FAIL reset_cnt got=%0d/%0d/%0d exp=0/0/0", birth_cnt, death_cnt, gen_cnt);
    end
    @(negedge clk);
    load = 1'b0;
    enable = 1'b0;
    load_board = '0;
    reset = 1'b0;
  endtask

  task automatic test_blinker();
    logic [CELLS-1:0] h, v;
    h = '0;
    h = setCell(h, 7, 6); h = setCell(h, 7, 7); h = setCell(h, 7, 8);
    v = '0;
    v = setCell(v, 6, 7); v = setCell(v, 7, 7); v = setCell(v, 8, 7);
    applyStimulus(1'b1, 1'b0, h);
    tests++;
    if (board !== h) begin
      failures++;
      $display("[TB] FAIL blinker_load got=%h exp=%h", board, h);
    end
    applyStimulus(1'b0, 1'b1, '0);
    tests++;
    if (board !== v) begin
      failures++;
      $display("[TB] FAIL blinker_gen1 got=%h exp=%h", board, v);
    end
    tests++;
    if (birth_cnt !== 32'd2 || death_cnt !== 32'd2 || gen_cnt !== 32'd1) begin
      failures++;
      $display("[TB] FAIL blinker_cnt1 got=%0d/%0d/%0d exp=2/2/1", birth_cnt, death_cnt, gen_cnt);
    end
    applyStimulus(1'b0, 1'b1, '0);
    tests++;
    if (board !== h) begin
      failures++;
      $display("[TB] FAIL blinker_gen2 got=%h exp=%h", board, h);
    end
    tests++;
    if (birth_cnt !== 32'd4 || death_cnt !== 32'd4 || gen_cnt !== 32'd2) begin
      failures++;
      $display("[TB] FAIL blinker_cnt2 got=%0d/%0d/%0d exp=4/4/2", birth_cnt, death_cnt, gen_cnt);
    end
  endtask

  task automatic test_still_life();
    logic [CELLS-1:0] blk;
    blk = '0;
    blk = setCell(blk, 0, 0); blk = setCell(blk, 0, 1);
    blk = setCell(blk, 1, 0); blk = setCell(blk, 1, 1);
    applyStimulus(1'b1, 1'b0, blk);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, '0);
    tests++;
    if (board !== blk) begin
      failures++;
      $display("[TB] FAIL still_board got=%h exp=%h", board, blk);
    end
    tests++;
    if (birth_cnt !== 32'd0 || death_cnt !== 32'd0 || gen_cnt !== 32'd5) begin
      failures++;
      $display("[TB] FAIL still_cnt got=%0d/%0d/%0d exp=0/0/5", birth_cnt, death_cnt, gen_cnt);
    end
  endtask

  task automatic test_dead_border();
    logic [CELLS-1:0] start, exp;
    start = '0;
    start = setCell(start, 0, 14); start = setCell(start, 0, 15);
    start = setCell(start, 1, 15);
    exp = setCell(start, 1, 14);
    applyStimulus(1'b1, 1'b0, start);
    applyStimulus(1'b0, 1'b1, '0);
    tests++;
    if (board !== exp) begin
      failures++;
      $display("[TB] FAIL border_board got=%h exp=%h", board, exp);
    end
    tests++;
    if (birth_cnt !== 32'd1 || death_cnt !== 32'd0 || gen_cnt !== 32'd1) begin
      failures++;
      $display("[TB] FAIL border_cnt got=%0d/%0d/%0d exp=1/0/1", birth_cnt, death_cnt, gen_cnt);
    end
  endtask

  task automatic test_priority();
    logic [CELLS-1:0] h;
    h = '0;
    h = setCell(h, 7, 6); h = setCell(h, 7, 7); h = setCell(h, 7, 8);
    applyStimulus(1'b1, 1'b1, h);
    tests++;
    if (board !== h) begin
      failures++;
      $display("[TB] FAIL prio_board got=%h exp=%h", board, h);
    end
    tests++;
    if ({birth_cnt, death_cnt, gen_cnt} !== 96'd0) begin
      failures++;
      $display("[TB] FAIL prio_cnt got=%0d/%0d/%0d exp=0/0/0", birth_cnt, death_cnt, gen_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, '1);
      tests++;
      if (board !== h || gen_cnt !== 32'd0 || birth_cnt !== 32'd0) begin
        failures++;
        $display("[TB] FAIL hold_%0d got=%h gen=%0d exp=%h gen=0", i, board, gen_cnt, h);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [CELLS-1:0] g, g4;
    g = '0;
    g = setCell(g, 4, 5); g = setCell(g, 5, 6);
    g = setCell(g, 6, 4); g = setCell(g, 6, 5); g = setCell(g, 6, 6);
    g4 = '0;
    g4 = setCell(g4, 5, 6); g4 = setCell(g4, 6, 7);
    g4 = setCell(g4, 7, 5); g4 = setCell(g4, 7, 6); g4 = setCell(g4, 7, 7);
    applyStimulus(1'b1, 1'b0, g);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, '0);
    tests++;
    if (board !== g4 || gen_cnt !== 32'd4) begin
      failures++;
      $display("[TB] FAIL glider_gen4 got=%h gen=%0d exp=%h gen=4", board, gen_cnt, g4);
    end
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if (board !== '0) begin
      failures++;
      $display("[TB] FAIL async_board got=%h exp=0", board);
    end
    tests++;
    if ({birth_cnt, death_cnt, gen_cnt} !== 96'd0) begin
      failures++;
      $display("[TB] FAIL async_cnt got=%0d/%0d/%0d exp=0/0/0", birth_cnt, death_cnt, gen_cnt);
    end
    #1;
    reset = 1'b0;
  endtask

  task automatic test_counter_wrap();
    logic [CELLS-1:0] h;
    h = '0;
    h = setCell(h, 7, 6); h = setCell(h, 7, 7); h = setCell(h, 7, 8);
    applyStimulus(1'b1, 1'b0, h);
    force dut.birth_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.birth_cnt_q;
    applyStimulus(1'b0, 1'b1, '0);
    tests++;
    if (birth_cnt !== 32'd1) begin
      failures++;
      $display("[TB] FAIL wrap_birth got=%h exp=00000001", birth_cnt);
    end
    tests++;
    if (death_cnt !== 32'd2 || gen_cnt !== 32'd1) begin
      failures++;
      $display("[TB] FAIL wrap_other got=%0d/%0d exp=2/1", death_cnt, gen_cnt);
    end
  endtask

  initial begin
    tests      = 0;
    failures   = 0;
    reset      = 1'b1;
    enable     = 1'b0;
    load       = 1'b0;
    load_board = '0;
    test_reset();
    test_blinker();
    test_still_life();
    test_dead_border();
    test_priority();
    test_async_reset();
    test_counter_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
